// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath select codes, instruction field constants and small decode helpers.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctl_t;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } result_src_t;

   typedef enum logic [1:0] {
      SRCB_WDATA  = 2'b00,
      SRCB_EXTIMM = 2'b01,
      SRCB_FOUR   = 2'b10
   } alusrcb_t;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   // Unrecognised commands fall back to ADD.
   function automatic alu_ctl_t cmd_to_alu(input logic [3:0] cmd);
      alu_ctl_t ctl;
      case (cmd)
         CMD_ADD: ctl = ALU_ADD;
         CMD_SUB: ctl = ALU_SUB;
         CMD_CMP: ctl = ALU_SUB;
         CMD_AND: ctl = ALU_AND;
         CMD_ORR: ctl = ALU_ORR;
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

   function automatic logic cmd_sets_cv(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation of a 4-bit Cond field against
// the NZCV flags; 1111 never executes.
module cond_check
   import multicycle_ctrl_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = i_flags[3];
   assign w_z = i_flags[2];
   assign w_c = i_flags[1];
   assign w_v = i_flags[0];

   // Condition lookup
   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = (w_n == w_v);
         COND_LT: o_cond_ex = (w_n != w_v);
         COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
         COND_LE: o_cond_ex = w_z | (w_n != w_v);
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: decodes the IR, holds NZCV and the latched condition
// result, and sequences every datapath select and write enable per state.
module multicycle_control_fsm
   import multicycle_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUControl,
   output logic        IllegalOp,
   output logic [3:0]  State
);

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_flags;
   logic        r_cond_ex;
   logic        w_cond_ex;

   logic [3:0]  w_cond;
   logic [1:0]  w_op;
   logic [5:0]  w_funct;
   logic [3:0]  w_rd;
   logic [3:0]  w_cmd;
   logic        w_unused_rn;

   logic        w_pc_write;
   logic        w_adr_src;
   logic        w_mem_write;
   logic        w_ir_write;
   logic        w_reg_write;
   result_src_t w_res_src;
   logic        w_alu_src_a;
   alusrcb_t    w_alu_src_b;
   alu_ctl_t    w_alu_ctl;
   logic        w_illegal;

   assign w_cond      = Instr[19:16];
   assign w_op        = Instr[15:14];
   assign w_funct     = Instr[13:8];
   assign w_rd        = Instr[3:0];
   assign w_cmd       = w_funct[4:1];
   assign w_unused_rn = ^Instr[7:4];

   cond_check u_cond_check (
      .i_cond    (w_cond),
      .i_flags   (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   // State, flags and latched condition result
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_flags   <= 4'b0000;
         r_cond_ex <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_DECODE) begin
            r_cond_ex <= w_cond_ex;
         end
         if (((r_state == S_EXECR) || (r_state == S_EXECI)) && r_cond_ex && w_funct[0]) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (cmd_sets_cv(w_cmd)) begin
               r_flags[1:0] <= ALUFlags[1:0];
            end
         end
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      w_next_state = S_FETCH;
      w_pc_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_res_src    = RES_ALUOUT;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = SRCB_WDATA;
      w_alu_ctl    = ALU_ADD;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_ir_write   = 1'b1;
            w_pc_write   = 1'b1;
            w_alu_src_a  = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_res_src    = RES_ALURESULT;
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_res_src   = RES_ALURESULT;
            w_illegal   = (w_op == OP_ILL);
            case (w_op)
               OP_MEM:  w_next_state = S_MEMADR;
               OP_DP:   w_next_state = w_funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   w_next_state = S_BRANCH;
               default: w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            w_alu_src_b  = SRCB_EXTIMM;
            w_alu_ctl    = w_funct[3] ? ALU_ADD : ALU_SUB;
            w_next_state = w_funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_adr_src    = 1'b1;
            w_next_state = S_MEMWB;
         end
         S_MEMWB: begin
            w_res_src    = RES_DATA;
            w_reg_write  = r_cond_ex;
            w_pc_write   = w_reg_write & (w_rd == 4'd15);
            w_next_state = S_FETCH;
         end
         S_MEMWR: begin
            w_adr_src    = 1'b1;
            w_mem_write  = r_cond_ex;
            w_next_state = S_FETCH;
         end
         S_EXECR: begin
            w_alu_ctl    = cmd_to_alu(w_cmd);
            w_next_state = S_ALUWB;
         end
         S_EXECI: begin
            w_alu_src_b  = SRCB_EXTIMM;
            w_alu_ctl    = cmd_to_alu(w_cmd);
            w_next_state = S_ALUWB;
         end
         S_ALUWB: begin
            // CMP only updates flags; a write to R15 also reloads the PC
            w_reg_write  = r_cond_ex & (w_cmd != CMD_CMP);
            w_pc_write   = w_reg_write & (w_rd == 4'd15);
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_b  = SRCB_EXTIMM;
            w_res_src    = RES_ALURESULT;
            w_pc_write   = r_cond_ex;
            w_next_state = S_FETCH;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   assign PCWrite    = w_pc_write  & ~reset;
   assign MemWrite   = w_mem_write & ~reset;
   assign IRWrite    = w_ir_write  & ~reset;
   assign RegWrite   = w_reg_write & ~reset;
   assign IllegalOp  = w_illegal   & ~reset;
   assign AdrSrc     = w_adr_src;
   assign ResultSrc  = w_res_src;
   assign ALUSrcA    = w_alu_src_a;
   assign ALUSrcB    = w_alu_src_b;
   assign ALUControl = w_alu_ctl;
   assign ImmSrc     = w_op;
   assign RegSrc     = {(w_op == OP_MEM) & ~w_funct[0], (w_op == OP_BR)};
   assign State      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction table, reset corner
// cases and random instruction streams checked against an instruction-level model.
module tb_multicycle_control_fsm;
   import multicycle_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, IllegalOp;
   logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
   logic [3:0]  State;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .IllegalOp(IllegalOp),
      .State(State)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] res;
      logic       srca;
      logic [1:0] srcb, imm, regsrc, aluc;
      logic       ill;
   } obs_t;

   obs_t w_obs;
   assign w_obs = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, IllegalOp};

   typedef struct {
      logic [19:0] ins;
      logic [3:0]  af;
      logic [3:0]  flags;
      int          cycles;
      string       nm;
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] m_flags;

   task automatic check_obs(input string nm, input obs_t e, input obs_t m);
      n_checks++;
      if ((w_obs & m) !== (e & m)) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (mask %h) t=%0t", nm, w_obs & m, e & m, m, $time);
      end
   endtask

   task automatic check_val(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // ARM condition: base test from Cond[3:1], Cond[0] inverts; 1111 thus never runs
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   function automatic logic [1:0] alu_code(input logic [3:0] cmd);
      if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
      if (cmd == 4'b0000) return 2'b10;
      if (cmd == 4'b1100) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                      input logic [5:0] f, input logic [3:0] rd);
      return {c, op, f, 4'h2, rd};
   endfunction

   // Expected outputs (value and care-mask) for one cycle in state s
   task automatic expect_state(input state_t s, input logic [19:0] ins, input bit cx,
                               output obs_t e, output obs_t m);
      logic [1:0] op;
      logic [5:0] f;
      op = ins[15:14];
      f  = ins[13:8];
      e = '0;
      m = '0;
      m.st = 4'hF; m.pcw = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
      m.imm = 2'b11; m.regsrc = 2'b11;
      e.st = s;
      e.imm = op;
      e.regsrc = {(op == 2'b01) && !f[0], (op == 2'b10)};
      case (s)
         S_FETCH: begin
            e.irw = 1'b1; e.pcw = 1'b1; e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10;
            m.adr = 1'b1; m.srca = 1'b1; m.srcb = 2'b11; m.aluc = 2'b11; m.res = 2'b11;
         end
         S_DECODE: begin
            e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; e.ill = (op == 2'b11);
            m.srca = 1'b1; m.srcb = 2'b11; m.aluc = 2'b11; m.res = 2'b11;
         end
         S_MEMADR: begin
            e.srcb = 2'b01; e.aluc = f[3] ? 2'b00 : 2'b01;
            m.srca = 1'b1; m.srcb = 2'b11; m.aluc = 2'b11;
         end
         S_MEMRD: begin
            e.adr = 1'b1; m.adr = 1'b1; m.res = 2'b11;
         end
         S_MEMWB: begin
            e.res = 2'b01; e.rw = cx; e.pcw = cx && (ins[3:0] == 4'd15); m.res = 2'b11;
         end
         S_MEMWR: begin
            e.adr = 1'b1; e.mw = cx; m.adr = 1'b1; m.res = 2'b11;
         end
         S_EXECR, S_EXECI: begin
            e.srcb = (s == S_EXECI) ? 2'b01 : 2'b00; e.aluc = alu_code(f[4:1]);
            m.srca = 1'b1; m.srcb = 2'b11; m.aluc = 2'b11;
         end
         S_ALUWB: begin
            e.rw = cx && (f[4:1] != 4'b1010); e.pcw = e.rw && (ins[3:0] == 4'd15);
            m.res = 2'b11;
         end
         default: begin
            e.srcb = 2'b01; e.res = 2'b10; e.pcw = cx;
            m.srca = 1'b1; m.srcb = 2'b11; m.aluc = 2'b11; m.res = 2'b11;
         end
      endcase
   endtask

   // Run one instruction from FETCH; report how many cycles the DUT took
   task automatic run_instr(input logic [19:0] ins, input logic [3:0] af,
                            input string nm, output int dut_len);
      state_t seq[$];
      state_t s;
      bit     cx;
      obs_t   e, m;
      Instr    = ins;
      ALUFlags = af;
      cx = cond_holds(ins[19:16], m_flags);
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (ins[15:14])
         2'b00: begin
            seq.push_back(ins[13] ? S_EXECI : S_EXECR);
            seq.push_back(S_ALUWB);
         end
         2'b01: begin
            seq.push_back(S_MEMADR);
            if (ins[8]) begin
               seq.push_back(S_MEMRD);
               seq.push_back(S_MEMWB);
            end else begin
               seq.push_back(S_MEMWR);
            end
         end
         2'b10: seq.push_back(S_BRANCH);
         default: ;
      endcase
      dut_len = -1;
      for (int k = 0; k < seq.size(); k++) begin
         s = seq[k];
         @(negedge clk);
         if (k > 0 && State == S_FETCH && dut_len < 0) dut_len = k;
         expect_state(s, ins, cx, e, m);
         check_obs($sformatf("%s.%s", nm, s.name()), e, m);
         @(posedge clk); #1;
      end
      if (dut_len < 0) dut_len = (State == S_FETCH) ? seq.size() : seq.size() + 1;
      if (ins[15:14] == 2'b00 && cx && ins[8]) begin
         m_flags[3:2] = af[3:2];
         if (ins[12:9] == 4'b0100 || ins[12:9] == 4'b0010 || ins[12:9] == 4'b1010)
            m_flags[1:0] = af[1:0];
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t       vt[15];
      obs_t       en_m;
      obs_t       zero_e;
      int         len;
      logic [3:0] cmds[5];
      logic [3:0] c, rd, cmd;
      logic [1:0] op;
      logic [5:0] f;

      cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
      cmds[3] = 4'b1100; cmds[4] = 4'b1010;

      vt[0]  = '{mk(4'hE, 2'b00, 6'b001001, 4'd1),  4'b0110, 4'b0110, 4, "adds"};
      vt[1]  = '{mk(4'hE, 2'b00, 6'b010101, 4'd0),  4'b0100, 4'b0100, 4, "cmp_z1"};
      vt[2]  = '{mk(4'h0, 2'b10, 6'b100000, 4'd0),  4'b0000, 4'b0100, 3, "beq_taken"};
      vt[3]  = '{mk(4'hE, 2'b00, 6'b010101, 4'd0),  4'b0000, 4'b0000, 4, "cmp_z0"};
      vt[4]  = '{mk(4'h0, 2'b10, 6'b100000, 4'd0),  4'b1111, 4'b0000, 3, "beq_not"};
      vt[5]  = '{mk(4'hE, 2'b01, 6'b011001, 4'd4),  4'b1111, 4'b0000, 5, "ldr"};
      vt[6]  = '{mk(4'hE, 2'b01, 6'b011000, 4'd4),  4'b1111, 4'b0000, 4, "str"};
      vt[7]  = '{mk(4'hE, 2'b00, 6'b010101, 4'd0),  4'b0100, 4'b0100, 4, "cmp_z1b"};
      vt[8]  = '{mk(4'h1, 2'b00, 6'b000101, 4'd3),  4'b1011, 4'b0100, 4, "subs_ne"};
      vt[9]  = '{mk(4'hE, 2'b00, 6'b001000, 4'd15), 4'b1111, 4'b0100, 4, "add_pc"};
      vt[10] = '{mk(4'hE, 2'b11, 6'b000000, 4'd1),  4'b1111, 4'b0100, 2, "illegal"};
      vt[11] = '{mk(4'hE, 2'b01, 6'b011001, 4'd15), 4'b0000, 4'b0100, 5, "ldr_pc"};
      vt[12] = '{mk(4'hE, 2'b00, 6'b111001, 4'd5),  4'b1011, 4'b1000, 4, "orrs_imm"};
      vt[13] = '{mk(4'hE, 2'b00, 6'b000001, 4'd6),  4'b0111, 4'b0100, 4, "ands"};
      vt[14] = '{mk(4'hF, 2'b00, 6'b001001, 4'd7),  4'b1111, 4'b0100, 4, "adds_nv"};

      en_m = '0;
      en_m.pcw = 1'b1; en_m.mw = 1'b1; en_m.irw = 1'b1; en_m.rw = 1'b1; en_m.ill = 1'b1;
      zero_e = '0;

      // Power-on reset
      reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0; m_flags = 4'h0;
      @(posedge clk);
      @(negedge clk);
      check_val("por.state", State, S_FETCH);
      check_obs("por.enables", zero_e, en_m);
      check_val("por.flags", dut.r_flags, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 15; i++) begin
         run_instr(vt[i].ins, vt[i].af, vt[i].nm, len);
         check_val({vt[i].nm, ".cycles"}, len, vt[i].cycles);
         check_val({vt[i].nm, ".flags"}, dut.r_flags, vt[i].flags);
      end

      // Reset held two cycles starting in MEMRD
      Instr = mk(4'hE, 2'b01, 6'b011001, 4'd4);
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_val("rst.mid_state", State, S_MEMRD);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_obs("rst.cyc1_enables", zero_e, en_m);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("rst.cyc2_state", State, S_FETCH);
      check_obs("rst.cyc2_enables", zero_e, en_m);
      check_val("rst.flags", dut.r_flags, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_flags = 4'h0;
      run_instr(mk(4'hE, 2'b00, 6'b001001, 4'd1), 4'b0110, "post_rst_adds", len);
      check_val("post_rst_adds.cycles", len, 4);

      // Random instruction stream against the model
      for (int i = 0; i < 400; i++) begin
         c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
         op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         f  = 6'($urandom_range(0, 63));
         if (op == 2'b00 && $urandom_range(0, 4) != 0) begin
            cmd = cmds[$urandom_range(0, 4)];
            f[4:1] = cmd;
         end
         rd = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         run_instr(mk(c, op, f, rd), 4'($urandom_range(0, 15)), $sformatf("rnd%0d", i), len);
      end
      check_val("rnd.flags", dut.r_flags, m_flags);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
